// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master: width defaults and FSM states.
package apb_pkg;

  localparam int unsigned APB_ADDRWIDTH      = 8;
  localparam int unsigned APB_DATAWIDTH      = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module apb_rr_arb (
  input  logic [1:0] req_mask_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the eligible request mask and the last granted index
  always_comb begin
    grant_o = '0;
    case (req_mask_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters with round-robin arbitration.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned ADDRWIDTH      = APB_ADDRWIDTH,
  parameter int unsigned DATAWIDTH      = APB_DATAWIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req,
  input  logic [1:0]                req_write,
  input  logic [1:0][ADDRWIDTH-1:0] req_addr,
  input  logic [1:0][DATAWIDTH-1:0] req_wdata,
  output logic [1:0]                req_ack,
  output logic [DATAWIDTH-1:0]      req_rdata,
  output logic                      req_err,
  output logic [ADDRWIDTH-1:0]      paddr,
  output logic [DATAWIDTH-1:0]      pwdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  input  logic [DATAWIDTH-1:0]      prdata,
  input  logic                      pready
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q, state_d;

  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]           ack_q, ack_d;
  logic                 last_q, last_d;   // index of the requester granted most recently

  logic [1:0] grant;
  logic       gsel;
  logic       tmo_hit;

  // A requester being acked this cycle still holds req; keep it out of arbitration
  apb_rr_arb u_arb (
    .req_mask_i   (req & ~ack_q),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  assign gsel = grant[1];

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign tmo_hit = (state_q == ACCESS) && !pready &&
                   (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  // Count ACCESS wait cycles; cleared whenever the bus is not stalled
  always_comb begin
    cnt_d = '0;
    if (state_q == ACCESS && !pready && !tmo_hit) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter and error flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Error flag accompanies the ack of a timed-out transfer only
  always_comb begin
    err_d = tmo_hit;
  end

  assign req_err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign req_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grant) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus and requester outputs
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    last_d    = last_q;
    ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          last_d    = gsel;
          pwrite_d  = req_write[gsel];
          paddr_d   = req_addr[gsel];
          pwdata_d  = req_wdata[gsel];
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          ack_d[last_q] = 1'b1;
          if (!pwrite_q) rdata_d = prdata;
        end else if (tmo_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          ack_d[last_q] = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Output and transfer-context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_rdata = rdata_q;
  assign req_ack   = ack_q;

endmodule
